pipe_stage_skid: RTL

// - Parametrised inter-stage pipeline register (ID->EX class) with valid/ready handshake and a 1-entry skid buffer.
// - Per-operand forwarding override applied at capture; flush turns held entries into bubbles.
// - Sits between decode and execute in the miniRV pipeline; one instance per stage boundary.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_fwd_mux.sv | 22 ++
 rtl/pipe_stage_skid.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for miniRV inter-stage pipeline registers.
package pipe_pkg;

  // Occupancy of a skid stage: head only, or head plus skid entry.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } pipe_state_e;

  // Control bundle field layout, shared with the decoder.
  localparam int unsigned CtrlBrOpLsb  = 0;
  localparam int unsigned CtrlBrOpW    = 3;
  localparam int unsigned CtrlRfWeBit  = 3;
  localparam int unsigned CtrlRamWeBit = 4;
  localparam int unsigned CtrlAluOpLsb = 5;
  localparam int unsigned CtrlAluOpW   = 4;

  localparam logic [2:0] BrOpNone = 3'b111;

  // Bubble: no branch, every write enable low.
  localparam logic [15:0] CtrlNop = 16'h0007;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Per-operand forwarding select applied to operands on their way into a stage register.
module pipe_fwd_mux #(
  parameter int unsigned NUM_OPND = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic [NUM_OPND*XLEN-1:0] opnd_i,
  input  logic [NUM_OPND-1:0]      fwd_en_i,
  input  logic [NUM_OPND*XLEN-1:0] fwd_data_i,
  output logic [NUM_OPND*XLEN-1:0] opnd_o
);

  // Replace each operand whose forward enable is set.
  always_comb begin
    opnd_o = opnd_i;
    for (int unsigned k = 0; k < NUM_OPND; k++) begin
      if (fwd_en_i[k]) begin
        opnd_o[k*XLEN +: XLEN] = fwd_data_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// The head entry drives the outputs; the skid entry catches the one transfer that arrives
// in the cycle downstream stops accepting.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned        XLEN     = 32,
  parameter int unsigned        CTRL_W   = 16,
  parameter int unsigned        NUM_OPND = 2,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CtrlNop)
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_OPND*XLEN-1:0] in_opnd,
  input  logic [NUM_OPND-1:0]      fwd_en,
  input  logic [NUM_OPND*XLEN-1:0] fwd_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_OPND*XLEN-1:0] out_opnd,
  output logic [15:0]              stall_cnt
);

  pipe_state_e state_q, state_d;

  logic [XLEN-1:0]          h_pc_q, s_pc_q;
  logic [CTRL_W-1:0]        h_ctrl_q, s_ctrl_q;
  logic [NUM_OPND*XLEN-1:0] h_opnd_q, s_opnd_q;
  logic [15:0]              stall_cnt_q;

  logic [NUM_OPND*XLEN-1:0] cap_opnd;
  logic                     acc, deq;
  logic                     h_load_in, h_load_s, s_load;

  // Forwarding is resolved once here; both entries capture from the same value.
  pipe_fwd_mux #(
    .NUM_OPND (NUM_OPND),
    .XLEN     (XLEN)
  ) u_fwd_mux (
    .opnd_i     (in_opnd),
    .fwd_en_i   (fwd_en),
    .fwd_data_i (fwd_data),
    .opnd_o     (cap_opnd)
  );

  assign in_ready  = (state_q != StSkid) && cpu_rst_n;
  assign out_valid = (state_q != StEmpty);
  assign acc       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  // Next state and entry load selects; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    h_load_in = 1'b0;
    h_load_s  = 1'b0;
    s_load    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          h_load_in = 1'b1;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (acc && deq) begin
          h_load_in = 1'b1;
        end else if (acc) begin
          s_load  = 1'b1;
          state_d = StSkid;
        end else if (deq) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (deq) begin
          h_load_s = 1'b1;
          state_d  = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d   = StEmpty;
      h_load_in = 1'b0;
      h_load_s  = 1'b0;
      s_load    = 1'b0;
    end
  end

  // Occupancy state register.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Head entry: loads from the input or promotes the skid entry.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      h_pc_q   <= '0;
      h_ctrl_q <= CTRL_NOP;
      h_opnd_q <= '0;
    end else if (flush) begin
      h_pc_q   <= '0;
      h_ctrl_q <= CTRL_NOP;
    end else if (h_load_in) begin
      h_pc_q   <= in_pc;
      h_ctrl_q <= in_ctrl;
      h_opnd_q <= cap_opnd;
    end else if (h_load_s) begin
      h_pc_q   <= s_pc_q;
      h_ctrl_q <= s_ctrl_q;
      h_opnd_q <= s_opnd_q;
    end
  end

  // Skid entry: only written when the head is stuck and a new entry arrives.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      s_pc_q   <= '0;
      s_ctrl_q <= CTRL_NOP;
      s_opnd_q <= '0;
    end else if (flush) begin
      s_pc_q   <= '0;
      s_ctrl_q <= CTRL_NOP;
    end else if (s_load) begin
      s_pc_q   <= in_pc;
      s_ctrl_q <= in_ctrl;
      s_opnd_q <= cap_opnd;
    end
  end

  // Saturating count of back-pressured cycles; flush leaves it alone.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Bubbles present as a NOP at PC 0; operands just show the last stored value.
  always_comb begin
    out_pc    = out_valid ? h_pc_q : '0;
    out_ctrl  = out_valid ? h_ctrl_q : CTRL_NOP;
    out_opnd  = h_opnd_q;
    stall_cnt = stall_cnt_q;
  end

endmodule
